// File: rtl/sipo_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// sipo_defs
// Shared definitions for the serial-in / parallel-out deserializer:
//   - state_e    : FSM state encoding (ST_COLLECT, ST_FULL)
//   - cnt_width(): bit-counter width for a given word width (clog2(WIDTH))
// -----------------------------------------------------------------------------
package sipo_defs;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_e;

    // Counter must hold 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// -----------------------------------------------------------------------------
// sipo_deserializer_if
// Groups the serial input handshake and the parallel output handshake.
//   d_in, d_valid, d_ready : one bit per transfer (valid/ready)
//   q_out, q_valid, q_ready: one WIDTH-bit word per transfer (valid/ready)
// Modports:
//   slave  : the deserializer's view (consumes bits, produces words)
//   master : the environment's view (produces bits, consumes words)
// -----------------------------------------------------------------------------
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             d_in;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] q_out;
    logic             q_valid;
    logic             q_ready;

    modport slave (
        input  d_in,
        input  d_valid,
        output d_ready,
        output q_out,
        output q_valid,
        input  q_ready
    );

    modport master (
        output d_in,
        output d_valid,
        input  d_ready,
        input  q_out,
        input  q_valid,
        output q_ready
    );
endinterface

// File: rtl/sipo_deserializer_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// WIDTH-bit shift register that collects serial bits.
//   clock    : rising-edge clock
//   clear    : synchronous clear to zero (highest priority)
//   shift_en : shift bit_in in on this edge
//   bit_in   : incoming serial bit
//   sr_o     : current register contents
//   word_o   : contents after shifting bit_in in (the value loaded on a
//              shift); lets the parent capture a completed word on the
//              same edge the last bit arrives
// MSB_FIRST=1 shifts left (new bit into bit 0), so the first bit ends up in
// the MSB; MSB_FIRST=0 shifts right (new bit into the MSB).
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] sr_o,
    output logic [WIDTH-1:0] word_o
);
    logic [WIDTH-1:0] sr_q;

    generate
        if (MSB_FIRST) begin : g_msb
            // Next value when shifting left.
            always_comb begin
                word_o = {sr_q[WIDTH-2:0], bit_in};
            end
        end else begin : g_lsb
            // Next value when shifting right.
            always_comb begin
                word_o = {bit_in, sr_q[WIDTH-1:1]};
            end
        end
    endgenerate

    // Shift register state.
    always_ff @(posedge clock) begin
        if (clear) begin
            sr_q <= {WIDTH{1'b0}};
        end else if (shift_en) begin
            sr_q <= word_o;
        end else begin
            sr_q <= sr_q;
        end
    end

    assign sr_o = sr_q;

endmodule

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
// Receives one bit per clock on a valid/ready handshake and assembles
// WIDTH-bit words, presented on a valid/ready parallel port. The shift
// register and the output holding register form a double buffer: a new word
// is collected while the previous one waits for the consumer.
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : sipo_deserializer_if.slave (d_in/d_valid/d_ready,
//           q_out/q_valid/q_ready)
// -----------------------------------------------------------------------------
module sipo_deserializer
    import sipo_defs::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    sipo_deserializer_if.slave    bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic             q_valid_q, q_valid_d;

    logic             accept_s;
    logic             last_s;
    logic             drain_s;
    logic [WIDTH-1:0] sr_s;
    logic [WIDTH-1:0] word_s;

    // d_ready depends only on registered state and the reset input.
    assign bus.d_ready = (state_q == ST_COLLECT) & reset;
    assign accept_s    = bus.d_valid & bus.d_ready;
    assign last_s      = (cnt_q == CNT_LAST);
    assign drain_s     = q_valid_q & bus.q_ready;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr (
        .clock    (clock),
        .clear    (~reset),
        .shift_en (accept_s),
        .bit_in   (bus.d_in),
        .sr_o     (sr_s),
        .word_o   (word_s)
    );

    // Next-state logic for FSM, bit counter and holding register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_out_d   = q_out_q;
        q_valid_d = q_valid_q;

        // A drain empties the holding register unless a reload below refills it.
        if (drain_s) begin
            q_valid_d = 1'b0;
        end else begin
            q_valid_d = q_valid_q;
        end

        case (state_q)
            ST_COLLECT: begin
                if (accept_s) begin
                    if (last_s) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (!q_valid_q || bus.q_ready) begin
                            q_out_d   = word_s;
                            q_valid_d = 1'b1;
                        end else begin
                            // Holding register busy: the word stays in sr.
                            state_d = ST_FULL;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    q_out_d   = sr_s;
                    q_valid_d = 1'b1;
                    state_d   = ST_COLLECT;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= {CNT_W{1'b0}};
            q_out_q   <= {WIDTH{1'b0}};
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_out_q   <= q_out_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign bus.q_out   = q_out_q;
    assign bus.q_valid = q_valid_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: an MSB-first and an LSB-first instance share identical stimulus.
module tb_sipo_deserializer;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    sipo_deserializer_if #(.WIDTH(8)) bus_m ();
    sipo_deserializer_if #(.WIDTH(8)) bus_l ();

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clock (clock),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clock (clock),
        .reset (reset),
        .bus   (bus_l.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       d_in;
        logic       d_valid;
        logic       q_ready;
        logic       exp_d_ready;
        logic       exp_q_valid;
        logic [7:0] exp_q_m;
        logic [7:0] exp_q_l;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic v, input logic qr);
        bus_m.d_in    = d;
        bus_m.d_valid = v;
        bus_m.q_ready = qr;
        bus_l.d_in    = d;
        bus_l.d_valid = v;
        bus_l.q_ready = qr;
    endtask

    // Apply inputs, take one rising edge, then settle before sampling.
    task automatic cycle(input logic d, input logic v, input logic qr);
        drive(d, v, qr);
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic qr);
        for (int i = 7; i >= 0; i--) begin
            cycle(b[i], 1'b1, qr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // Reset held for two edges.
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_d_ready_low", {31'd0, bus_m.d_ready}, 32'd0);
        chk("rst_q_valid", {31'd0, bus_m.q_valid}, 32'd0);
        chk("rst_q_out", {24'd0, bus_m.q_out}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rel_d_ready", {31'd0, bus_m.d_ready}, 32'd1);

        // Single word 1,0,1,1,0,0,1,0 with q_ready=1.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hB2, 8'h4D};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB2, 8'h4D};
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].d_in, vecs[i].d_valid, vecs[i].q_ready);
            chk($sformatf("vec%0d_d_ready", i), {31'd0, bus_m.d_ready}, {31'd0, vecs[i].exp_d_ready});
            chk($sformatf("vec%0d_q_valid_m", i), {31'd0, bus_m.q_valid}, {31'd0, vecs[i].exp_q_valid});
            chk($sformatf("vec%0d_q_valid_l", i), {31'd0, bus_l.q_valid}, {31'd0, vecs[i].exp_q_valid});
            chk($sformatf("vec%0d_q_out_m", i), {24'd0, bus_m.q_out}, {24'd0, vecs[i].exp_q_m});
            chk($sformatf("vec%0d_q_out_l", i), {24'd0, bus_l.q_out}, {24'd0, vecs[i].exp_q_l});
        end

        // Backpressure: two words with q_ready=0.
        send_byte(8'hA5, 1'b0);
        chk("bp_first_valid", {31'd0, bus_m.q_valid}, 32'd1);
        chk("bp_first_word", {24'd0, bus_m.q_out}, 32'hA5);
        chk("bp_d_ready_after8", {31'd0, bus_m.d_ready}, 32'd1);
        send_byte(8'h3C, 1'b0);
        chk("bp_held_word", {24'd0, bus_m.q_out}, 32'hA5);
        chk("bp_d_ready_full", {31'd0, bus_m.d_ready}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0);   // bit 17 offered, must be refused
        chk("bp_bit17_refused", {31'd0, bus_m.d_ready}, 32'd0);
        chk("bp_still_held", {24'd0, bus_m.q_out}, 32'hA5);
        cycle(1'b0, 1'b0, 1'b1);
        chk("bp_reload_word", {24'd0, bus_m.q_out}, 32'h3C);
        chk("bp_reload_valid", {31'd0, bus_m.q_valid}, 32'd1);
        chk("bp_reload_d_ready", {31'd0, bus_m.d_ready}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("bp_drain_valid", {31'd0, bus_m.q_valid}, 32'd0);
        chk("bp_drain_hold", {24'd0, bus_m.q_out}, 32'h3C);

        // Gapped input: 8'hFF with d_valid toggling over 15 cycles.
        for (int c = 0; c < 15; c++) begin
            cycle(1'b1, (c % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
            if (c < 14) begin
                chk($sformatf("gap_c%0d_not_valid", c), {31'd0, bus_m.q_valid}, 32'd0);
            end else begin
                chk("gap_valid", {31'd0, bus_m.q_valid}, 32'd1);
                chk("gap_word", {24'd0, bus_m.q_out}, 32'hFF);
            end
        end
        cycle(1'b0, 1'b0, 1'b1);
        chk("gap_drain", {31'd0, bus_m.q_valid}, 32'd0);

        // Reset mid-word: 5 stale bits, one reset edge, then 8'h81.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b1);
        end
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        chk("mid_rst_d_ready", {31'd0, bus_m.d_ready}, 32'd0);
        chk("mid_rst_q_out", {24'd0, bus_m.q_out}, 32'd0);
        reset = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            cycle((i == 7) ? 1'b1 : 1'b0, 1'b1, 1'b1);
            chk($sformatf("mid_rst_bit%0d_not_valid", i), {31'd0, bus_m.q_valid}, 32'd0);
        end
        cycle(1'b1, 1'b1, 1'b1);
        chk("mid_rst_valid", {31'd0, bus_m.q_valid}, 32'd1);
        chk("mid_rst_word_m", {24'd0, bus_m.q_out}, 32'h81);
        chk("mid_rst_word_l", {24'd0, bus_l.q_out}, 32'h81);
        cycle(1'b0, 1'b0, 1'b1);
        chk("mid_rst_drain", {31'd0, bus_m.q_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
